ht_seq_trigger: RTL and testbench
=================================

# ht_seq_trigger

Parametrised sequential trojan-insertion block for the trojan-detection benchmark suite. It is the next generation of our combinational rare-node trojans, which place an AND trigger plus an XOR payload on one internal net. It monitors a configurable vector of host-circuit nets and counts occurrences of a rare masked value. After a programmable number of hits it arms a payload that corrupts a configurable vector of host nets in one of several modes. It sits between the host netlist's internal nets and their downstream fan-out, so the evolutionary pattern generator must find multi-cycle activating sequences, not a single vector.

## Interface
Parameters:
- TRIG_W, 8, number of monitored host nets.
- TRIG_VAL, 8'hA5, rare value the trigger compares against.
- TRIG_MASK, 8'hFF, compare mask; a 0 bit is don't-care.
- PAY_W, 4, number of payload nets passed through or corrupted.
- CNT_W, 8, hit-counter width.
- THRESH, 16, hits required to fire; legal range 1..2^CNT_W-1.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; hits count only while en=1.
- clr  in  1  synchronous return to IDLE; clears the counter.
- mode  in  2  payload mode: 0=pass, 1=invert, 2=stuck-0, 3=stuck-1.
- trig_nets  in  TRIG_W  monitored host nets.
- pay_in  in  PAY_W  host nets before the payload.
- pay_out  out  PAY_W  host nets after the payload; combinational.
- fired  out  1  registered; payload active.
- hit_cnt  out  CNT_W  registered hit count; saturates at THRESH.

## Operation
- Match: match = (((trig_nets ^ TRIG_VAL) & TRIG_MASK) == 0).
- A hit is en & match & !clr, counted once per cycle. Edge mode is described under Configuration.
- The state machine has three states:
  - IDLE: hit_cnt=0. A hit moves to COUNT with hit_cnt=1, or straight to FIRED if THRESH=1.
  - COUNT: each hit increments hit_cnt. The hit that makes hit_cnt reach THRESH moves to FIRED in the same cycle. Non-hit cycles hold hit_cnt, so there is no timeout.
  - FIRED: sticky. hit_cnt holds at THRESH and fired=1. Further hits are ignored.
- clr=1 moves any state to IDLE with hit_cnt=0. clr takes priority over a simultaneous hit.
- pay_out depends on fired and mode:
  - fired=0: pay_out = pay_in, for every mode.
  - fired=1, mode 0: pay_in.
  - fired=1, mode 1: ~pay_in.
  - fired=1, mode 2: all zeros.
  - fired=1, mode 3: all ones.
- mode is sampled combinationally. Changing mode while FIRED takes effect immediately.
- Counter arithmetic is unsigned CNT_W bits. hit_cnt never exceeds THRESH and never wraps.

## Timing
- Reset values:
  - State is IDLE.
  - hit_cnt = 0 and fired = 0.
  - pay_out = pay_in, combinationally, during and after reset.
- rst asserted mid-count or in FIRED clears everything asynchronously, with no clock needed. On deassertion the block resumes in IDLE.
- Trigger latency: the THRESH-th hit is sampled at edge N, and fired=1 after edge N. pay_out is corrupted from that cycle onward.
- pay_in to pay_out is combinational, zero cycles.
- clr takes effect on the next rising edge: fired=0 and hit_cnt=0 after that edge.
- en=0 freezes counting but does not un-fire the block.

## Configuration
- HT_EDGE_COUNT_EN:
  - Defined: a hit is a rising edge of match. A registered match_q is added, and a hit is en & match & !match_q & !clr, so a match held for many cycles counts once. match_q resets to 0, and clr clears match_q.
  - Undefined: a hit is counted every cycle the match holds. No match_q register exists.

## Test plan
- Cycle-count fire: reset, en=1, TRIG_VAL=8'hA5, THRESH=16, mode=1, pay_in=4'h3, trig_nets held at 8'hA5. Required: hit_cnt=1..16 on successive edges, fired=1 after the 16th edge, pay_out=4'hC from then on, and hit_cnt stuck at 16.
- Interleaved misses: alternate trig_nets between 8'hA5 and 8'h00 for 40 cycles. Required: fired after the 16th match, not the 16th cycle. With MASK=8'h0F, 8'h35 also counts as a hit.
- Modes: in FIRED with pay_in=4'h9, sweep mode 0..3. Required pay_out per mode: 9, 6, 0, F. Before firing, pay_out=9 in every mode.
- clr priority: issue clr=1 in the same cycle as the 16th hit. Required: fired stays 0 and hit_cnt=0 after the edge. Then 16 fresh hits fire the block.
- Async reset: assert rst mid-cycle at hit_cnt=7, and again while FIRED. Required: hit_cnt=0, fired=0 and pay_out=pay_in immediately, with no clock edge.
- Edge mode: with HT_EDGE_COUNT_EN defined, hold a match for 20 cycles, then toggle it 16 times. Required: hit_cnt=1 after the hold, and fired after the 15th rising edge of the toggles, 16 counted edges in total. Without the macro, the 20-cycle hold alone fires the block.

Source files
------------

// File: rtl/ht_seq_trigger.sv
`default_nettype none
// ============================================================================
// Module   : ht_seq_trigger
// Brief    : Sequential trojan trigger. Counts rare masked matches on host nets
//            and, after THRESH hits, corrupts the payload nets per mode.
//            Optional macro HT_EDGE_COUNT_EN: count rising edges of the match
//            instead of every matching cycle.
// Revision : 1.0  initial release
// ============================================================================
module ht_seq_trigger #(
    parameter int                TRIG_W    = 8,
    parameter logic [TRIG_W-1:0] TRIG_VAL  = 8'hA5,
    parameter logic [TRIG_W-1:0] TRIG_MASK = 8'hFF,
    parameter int                PAY_W     = 4,
    parameter int                CNT_W     = 8,
    parameter int                THRESH    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic [1:0]        mode,
    input  logic [TRIG_W-1:0] trig_nets,
    input  logic [PAY_W-1:0]  pay_in,
    output logic [PAY_W-1:0]  pay_out,
    output logic              fired,
    output logic [CNT_W-1:0]  hit_cnt
);

    localparam logic [CNT_W-1:0] c_thresh = CNT_W'(THRESH);
    localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_FIRED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             r_fired;
    logic             w_match;
    logic             w_hit;

    assign w_match = (((trig_nets ^ TRIG_VAL) & TRIG_MASK) == '0);

`ifdef HT_EDGE_COUNT_EN
    // Previous-cycle match so a held match registers as a single hit.
    logic r_match_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_match_q <= 1'b0;
        end else if (clr) begin
            r_match_q <= 1'b0;
        end else begin
            r_match_q <= w_match;
        end
    end

    assign w_hit = en & w_match & ~r_match_q & ~clr;
`else
    assign w_hit = en & w_match & ~clr;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_fired <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_fired <= (w_state_nx == S_FIRED);
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (clr) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        w_cnt_nx = c_one;
                        if (c_one == c_thresh) begin
                            w_state_nx = S_FIRED;
                        end else begin
                            w_state_nx = S_COUNT;
                        end
                    end
                end
                S_COUNT: begin
                    // r_cnt is always below THRESH here, so the increment cannot wrap.
                    if (w_hit) begin
                        w_cnt_nx = r_cnt + c_one;
                        if (w_cnt_nx == c_thresh) begin
                            w_state_nx = S_FIRED;
                        end
                    end
                end
                S_FIRED: begin
                    w_cnt_nx = c_thresh;
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    always_comb begin
        pay_out = pay_in;
        if (r_fired) begin
            case (mode)
                2'd0:    pay_out = pay_in;
                2'd1:    pay_out = ~pay_in;
                2'd2:    pay_out = '0;
                default: pay_out = '1;
            endcase
        end
    end

    assign fired   = r_fired;
    assign hit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ht_seq_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_ht_seq_trigger
// Brief    : Scoreboard bench for ht_seq_trigger with directed vectors.
// Revision : 1.0  initial release
// ============================================================================
module tb_ht_seq_trigger;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] trig;
    logic [3:0] pay_in;
    logic [3:0] pay_out;
    logic [3:0] pay_out_m;
    logic       fired;
    logic       fired_m;
    logic [7:0] hit_cnt;
    logic [7:0] hit_cnt_m;

    always #5 clk = ~clk;

    ht_seq_trigger u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .trig_nets(trig), .pay_in(pay_in), .pay_out(pay_out),
        .fired(fired), .hit_cnt(hit_cnt)
    );

    ht_seq_trigger #(.TRIG_MASK(8'h0F)) u_dut_m (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode),
        .trig_nets(trig), .pay_in(pay_in), .pay_out(pay_out_m),
        .fired(fired_m), .hit_cnt(hit_cnt_m)
    );

    typedef struct {
        logic [7:0] cnt;
        logic       fired;
        logic [3:0] pay;
        logic       chk_m;
        logic [7:0] cnt_m;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    // Monitor: outputs are stable at the falling edge; inputs change only after it.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, " hit_cnt"}, hit_cnt, e.cnt);
            chk({e.name, " fired"}, {7'd0, fired}, {7'd0, e.fired});
            chk({e.name, " pay_out"}, {4'd0, pay_out}, {4'd0, e.pay});
            if (e.chk_m) chk({e.name, " mask hit_cnt"}, hit_cnt_m, e.cnt_m);
        end
    end

    task automatic push(input logic [7:0] xc, input logic xf, input logic [3:0] xp,
                        input string nm, input logic cm, input logic [7:0] xcm);
        exp_t x;
        x.cnt = xc; x.fired = xf; x.pay = xp; x.chk_m = cm; x.cnt_m = xcm; x.name = nm;
        q.push_back(x);
    endtask

    task automatic step(input logic s_en, input logic s_clr, input logic [7:0] t,
                        input logic [1:0] m, input logic [3:0] p,
                        input logic [7:0] xc, input logic xf, input logic [3:0] xp,
                        input string nm, input logic cm = 1'b0, input logic [7:0] xcm = 8'h00);
        en = s_en; clr = s_clr; trig = t; mode = m; pay_in = p;
        @(posedge clk);
        push(xc, xf, xp, nm, cm, xcm);
        @(negedge clk);
        #1;
    endtask

    // n hit/gap pairs (counts identically with or without edge counting), mode 1, pay_in p.
    task automatic hits(input int n, input int start, input logic [3:0] p, input string nm);
        for (int k = 1; k <= n; k++) begin
            int   c;
            logic f;
            c = (start + k > 16) ? 16 : start + k;
            f = (c == 16);
            step(1'b1, 1'b0, 8'hA5, 2'd1, p, 8'(c), f, f ? ~p : p, $sformatf("%s_h%0d", nm, k));
            step(1'b1, 1'b0, 8'h00, 2'd1, p, 8'(c), f, f ? ~p : p, $sformatf("%s_g%0d", nm, k));
        end
    endtask

    // Reset asserted between edges; the monitor samples before any further rising edge.
    task automatic async_rst(input logic [3:0] p, input string nm);
        en = 1'b0; clr = 1'b0; pay_in = p; mode = 2'd1;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 push(8'h00, 1'b0, p, nm, 1'b0, 8'h00);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    logic [3:0] mode_pay [4];

    initial begin
        mode_pay = '{4'h9, 4'h6, 4'h0, 4'hF};
        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd1; trig = 8'h00; pay_in = 4'h3;
        @(negedge clk); #1;
        step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'd0, 1'b0, 4'h3, "reset");
        rst = 1'b0;

`ifndef HT_EDGE_COUNT_EN
        for (int i = 1; i <= 16; i++)
            step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'(i), i == 16, (i == 16) ? 4'hC : 4'h3,
                 $sformatf("count%0d", i));
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'd16, 1'b1, 4'hC, "saturate");
`endif

        step(1'b0, 1'b1, 8'h00, 2'd1, 4'h3, 8'd0, 1'b0, 4'h3, "clr");
        for (int m = 0; m < 4; m++)
            step(1'b0, 1'b0, 8'h00, 2'(m), 4'h9, 8'd0, 1'b0, 4'h9, $sformatf("premode%0d", m));

        for (int i = 0; i < 40; i++) begin
            int c;
            c = (i / 2 + 1 > 16) ? 16 : i / 2 + 1;
            step(1'b1, 1'b0, (i % 2 == 0) ? 8'hA5 : 8'h00, 2'd1, 4'h3, 8'(c), c == 16,
                 (c == 16) ? 4'hC : 4'h3, $sformatf("interleave%0d", i));
        end

        for (int m = 0; m < 4; m++)
            step(1'b0, 1'b0, 8'h00, 2'(m), 4'h9, 8'd16, 1'b1, mode_pay[m], $sformatf("mode%0d", m));

        step(1'b0, 1'b1, 8'h00, 2'd3, 4'h9, 8'd0, 1'b0, 4'h9, "clr2");
        hits(15, 0, 4'h3, "pre");
        step(1'b1, 1'b1, 8'hA5, 2'd1, 4'h3, 8'd0, 1'b0, 4'h3, "clr_prio");
        step(1'b0, 1'b0, 8'h00, 2'd1, 4'h3, 8'd0, 1'b0, 4'h3, "clr_prio_gap");
        hits(16, 0, 4'h3, "fresh");

        async_rst(4'h3, "rst_fired");
        hits(7, 0, 4'h3, "mid");
        step(1'b0, 1'b0, 8'h00, 2'd1, 4'h3, 8'd7, 1'b0, 4'h3, "mid_hold");
        async_rst(4'h3, "rst_mid");
        hits(1, 0, 4'h3, "resume");

        step(1'b0, 1'b1, 8'h00, 2'd0, 4'h5, 8'd0, 1'b0, 4'h5, "clr3", 1'b1, 8'd0);
        step(1'b1, 1'b0, 8'h35, 2'd0, 4'h5, 8'd0, 1'b0, 4'h5, "mask35a", 1'b1, 8'd1);
        step(1'b1, 1'b0, 8'h00, 2'd0, 4'h5, 8'd0, 1'b0, 4'h5, "mask00", 1'b1, 8'd1);
        step(1'b1, 1'b0, 8'h35, 2'd0, 4'h5, 8'd0, 1'b0, 4'h5, "mask35b", 1'b1, 8'd2);
        step(1'b1, 1'b0, 8'hA4, 2'd0, 4'h5, 8'd0, 1'b0, 4'h5, "maskA4", 1'b1, 8'd2);

        step(1'b0, 1'b1, 8'h00, 2'd1, 4'h3, 8'd0, 1'b0, 4'h3, "clr4");
`ifdef HT_EDGE_COUNT_EN
        for (int i = 1; i <= 20; i++)
            step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'd1, 1'b0, 4'h3, $sformatf("hold%0d", i));
        for (int k = 1; k <= 15; k++) begin
            step(1'b1, 1'b0, 8'h00, 2'd1, 4'h3, 8'(k), 1'b0, 4'h3, $sformatf("tog_lo%0d", k));
            step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'(k + 1), k == 15, (k == 15) ? 4'hC : 4'h3,
                 $sformatf("tog_hi%0d", k));
        end
`else
        for (int i = 1; i <= 20; i++)
            step(1'b1, 1'b0, 8'hA5, 2'd1, 4'h3, 8'((i > 16) ? 16 : i), i >= 16,
                 (i >= 16) ? 4'hC : 4'h3, $sformatf("hold%0d", i));
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
